// File: rtl/cpu_trace_pkg.sv
// Shared widths and record packing for the cpu retire-trace capture block.
// Optional macro TRACE_TIMESTAMP_EN prepends a 16-bit cycle timestamp to each record.
package cpu_trace_pkg;

  localparam int PC_W   = 6;
  localparam int DATA_W = 16;
  localparam int TS_W   = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_W  = TS_W + PC_W + DATA_W;
`else
  localparam int REC_W  = PC_W + DATA_W;
`endif

  function automatic logic [REC_W-1:0] rec_pack(input logic [TS_W-1:0]   ts,
                                                 input logic [PC_W-1:0]   pc,
                                                 input logic [DATA_W-1:0] data);
`ifdef TRACE_TIMESTAMP_EN
    return {ts, pc, data};
`else
    logic unused_ts;
    unused_ts = ^ts;
    return {pc, data};
`endif
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: synchronous-write RAM with registered pointers and an occupancy counter.
// Head is read combinationally; a push and pop on the same edge succeed even when full.
module trace_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt_q;
  // Empty FIFO presents zeros rather than stale RAM contents.
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LVL_W'(1);
      2'b01:   cnt_d = cnt_q - LVL_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Captures one {pc, out} record per PC change into a FIFO drained over valid/ready; counts overflow drops.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running 16-bit cycle timestamp to each record.
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_en,
  input  logic [DATA_W-1:0]      cpu_out,
  input  logic [PC_W-1:0]        cpu_pc,
  output logic [REC_W-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   clr_drops
);

  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              prime_q, prime_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              cap, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [REC_W-1:0]  rec;
  logic [TS_W-1:0]   ts_val;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end
  assign ts_val = ts_q;
`else
  assign ts_val = '0;
`endif

  assign rec      = rec_pack(ts_val, cpu_pc, cpu_out);
  assign m_valid  = ~fifo_empty;
  assign pop      = m_valid & m_ready;
  assign drop     = cap & fifo_full & ~pop;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

  // cpu_pc is only compared while enabled, so an undriven bus cannot leak into state.
  always_comb begin
    cap       = 1'b0;
    last_pc_d = last_pc_q;
    prime_d   = prime_q;
    if (!cap_en) begin
      prime_d = 1'b1;
    end else begin
      cap = prime_q | (cpu_pc != last_pc_q);
      if (cap) begin
        last_pc_d = cpu_pc;
        prime_d   = 1'b0;
      end
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_drops) begin
      ovf_d  = drop;
      drop_d = drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_pc_q <= '0;
      prime_q   <= 1'b1;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      prime_q   <= prime_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap),
    .din   (rec),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule
